mmio_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the MMIO device unit (RTC, CLINT mtimecmp).
- Requester 0 is the memory stage; requester 1 is a secondary master (debug/DMA path).
- Grants one access at a time and drives the device unit's start/req/ack handshake.
- Returns read data or a completion/error pulse to the owning requester.
- A watchdog terminates accesses whose req never rises.

---
 rtl/mmio_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mmio_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_arbiter.sv
// Two-requester arbiter/sequencer in front of the MMIO device unit.
// Grants one access at a time, drives start/ack toward the device, and
// returns a registered one-cycle done/err/rdata pulse to the owning port.
module mmio_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic        m0_ren,
  input  logic        m0_wen,
  input  logic [63:0] m0_addr,
  input  logic [63:0] m0_wdata,
  output logic        m0_ready,
  output logic        m0_done,
  output logic        m0_err,
  output logic [63:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_ren,
  input  logic        m1_wen,
  input  logic [63:0] m1_addr,
  input  logic [63:0] m1_wdata,
  output logic        m1_ready,
  output logic        m1_done,
  output logic        m1_err,
  output logic [63:0] m1_rdata,
  output logic        mmio_start,
  output logic        mmio_ack,
  input  logic        mmio_req,
  output logic        mmio_ren,
  output logic        mmio_wen,
  output logic [63:0] mmio_addr,
  output logic [63:0] mmio_wdata,
  input  logic [63:0] mmio_rdata,
  output logic        busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  // Last watchdog value before the access is abandoned.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state, state_nxt;
  logic             last;       // port granted most recently
  logic             owner;      // port owning the in-flight access
  logic [CNT_W-1:0] wdog, wdog_nxt;

  logic             win, accept;
  logic             sel_ren, sel_wen;
  logic [63:0]      sel_addr, sel_wdata;
  logic             pulse, pulse_err, tgt;
  logic [63:0]      pulse_data;

  // Round-robin pick: on a tie the port not granted last wins.
  always_comb begin
    win       = (m0_valid & m1_valid) ? ~last : m1_valid;
    // A pending device req (stale after reset/abort) blocks new grants.
    accept    = (state == S_IDLE) & ~mmio_req & (m0_valid | m1_valid);
    m0_ready  = accept & ~win;
    m1_ready  = accept & win;
    sel_ren   = win ? m1_ren   : m0_ren;
    sel_wen   = win ? m1_wen   : m0_wen;
    sel_addr  = win ? m1_addr  : m0_addr;
    sel_wdata = win ? m1_wdata : m0_wdata;
  end

  // Device-side handshake and status decode straight from the state.
  always_comb begin
    mmio_start = (state == S_ISSUE);
    mmio_ack   = (state == S_ACK);
    busy       = (state != S_IDLE);
  end

  // Next-state, watchdog and completion-pulse decode.
  always_comb begin
    state_nxt  = state;
    wdog_nxt   = wdog;
    pulse      = 1'b0;
    pulse_err  = 1'b0;
    pulse_data = 64'd0;
    tgt        = owner;
    case (state)
      S_IDLE: begin
        if (mmio_req) begin
          state_nxt = S_ACK;
        end else if (accept) begin
          tgt = win;
          // ren == wen is not a legal op: report it without touching the device.
          if (sel_ren == sel_wen) begin
            state_nxt = S_ERR;
            pulse     = 1'b1;
            pulse_err = 1'b1;
          end else begin
            state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wdog_nxt  = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mmio_req) begin
          pulse      = 1'b1;
          pulse_data = mmio_ren ? mmio_rdata : 64'd0;
          state_nxt  = S_ACK;
        end else if (wdog == WD_LAST) begin
          pulse     = 1'b1;
          pulse_err = 1'b1;
          state_nxt = S_ACK;
        end else begin
          wdog_nxt = wdog + CNT_W'(1);
        end
      end
      S_ACK: begin
        if (!mmio_req) state_nxt = S_IDLE;
      end
      S_ERR: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, grant bookkeeping and latched downstream request fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      last       <= 1'b1;
      owner      <= 1'b0;
      wdog       <= '0;
      mmio_ren   <= 1'b0;
      mmio_wen   <= 1'b0;
      mmio_addr  <= 64'd0;
      mmio_wdata <= 64'd0;
    end else begin
      state <= state_nxt;
      wdog  <= wdog_nxt;
      if (accept) begin
        owner      <= win;
        last       <= win;
        mmio_ren   <= sel_ren;
        mmio_wen   <= sel_wen;
        mmio_addr  <= sel_addr;
        mmio_wdata <= sel_wdata;
      end
    end
  end

  // One-cycle completion pulses, routed to the owning port only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0_done  <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= 64'd0;
      m1_done  <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= 64'd0;
    end else begin
      m0_done  <= pulse & ~tgt;
      m0_err   <= pulse & pulse_err & ~tgt;
      m0_rdata <= (pulse & ~tgt) ? pulse_data : 64'd0;
      m1_done  <= pulse & tgt;
      m1_err   <= pulse & pulse_err & tgt;
      m1_rdata <= (pulse & tgt) ? pulse_data : 64'd0;
    end
  end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter; the device side is driven by hand
// from the stimulus sequence, inputs change and outputs are sampled on
// the falling clock edge.
module tb_mmio_arbiter;

  localparam logic [63:0] DEV_RTC      = 64'h0000_0000_0000_0001;
  localparam logic [63:0] DEV_MTIMECMP = 64'h0000_0000_0000_0002;

  logic        clk, rst;
  logic        m0_valid, m0_ren, m0_wen, m0_ready, m0_done, m0_err;
  logic [63:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_valid, m1_ren, m1_wen, m1_ready, m1_done, m1_err;
  logic [63:0] m1_addr, m1_wdata, m1_rdata;
  logic        mmio_start, mmio_ack, mmio_req, mmio_ren, mmio_wen, busy;
  logic [63:0] mmio_addr, mmio_wdata, mmio_rdata;

  int checks = 0;
  int errors = 0;

  mmio_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ren(m0_ren), .m0_wen(m0_wen), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_done(m0_done), .m0_err(m0_err),
    .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ren(m1_ren), .m1_wen(m1_wen), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_done(m1_done), .m1_err(m1_err),
    .m1_rdata(m1_rdata),
    .mmio_start(mmio_start), .mmio_ack(mmio_ack), .mmio_req(mmio_req),
    .mmio_ren(mmio_ren), .mmio_wen(mmio_wen), .mmio_addr(mmio_addr),
    .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One normal access by port p with the device answering right after start.
  // Entered at a falling edge in IDLE with the request already driven.
  task automatic xfer(input bit p, input bit is_rd, input logic [63:0] d, input bit keep);
    #1;
    chk("ready_win",  p ? m1_ready : m0_ready, 64'd1);
    chk("ready_lose", p ? m0_ready : m1_ready, 64'd0);
    @(negedge clk);
    chk("start",   mmio_start, 64'd1);
    chk("busy",    busy,       64'd1);
    chk("lat_ren", mmio_ren,   {63'd0, is_rd});
    chk("lat_wen", mmio_wen,   {63'd0, !is_rd});
    if (!keep) begin
      if (p) m1_valid = 1'b0; else m0_valid = 1'b0;
    end
    mmio_req   = 1'b1;
    mmio_rdata = d;
    @(negedge clk);
    chk("start_low",  mmio_start,        64'd0);
    chk("done_early", m0_done | m1_done, 64'd0);
    @(negedge clk);
    chk("done",       p ? m1_done  : m0_done,  64'd1);
    chk("err",        p ? m1_err   : m0_err,   64'd0);
    chk("rdata",      p ? m1_rdata : m0_rdata, is_rd ? d : 64'd0);
    chk("other_done", p ? m0_done  : m1_done,  64'd0);
    chk("ack",        mmio_ack,   64'd1);
    chk("no_overlap", mmio_start, 64'd0);
    @(negedge clk);
    chk("done_pulse", p ? m1_done : m0_done, 64'd0);
    chk("ack_hold",   mmio_ack, 64'd1);
    mmio_req   = 1'b0;
    mmio_rdata = 64'd0;
    @(negedge clk);
    chk("idle",    busy,     64'd0);
    chk("ack_low", mmio_ack, 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    m0_valid = 0; m0_ren = 0; m0_wen = 0; m0_addr = 0; m0_wdata = 0;
    m1_valid = 0; m1_ren = 0; m1_wen = 0; m1_addr = 0; m1_wdata = 0;
    mmio_req = 0; mmio_rdata = 0;
    #12;
    chk("rst_busy",  busy,       64'd0);
    chk("rst_start", mmio_start, 64'd0);
    chk("rst_ack",   mmio_ack,   64'd0);
    chk("rst_addr",  mmio_addr,  64'd0);
    chk("rst_done",  m0_done | m1_done, 64'd0);
    chk("rst_rdata", m0_rdata | m1_rdata, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // m0 read of the RTC
    m0_valid = 1; m0_ren = 1; m0_wen = 0; m0_addr = DEV_RTC;
    xfer(1'b0, 1'b1, 64'h1234, 1'b0);
    chk("rtc_addr", mmio_addr, DEV_RTC);
    m0_ren = 0;

    // m1 write of mtimecmp; read data from the device must not leak back
    m1_valid = 1; m1_ren = 0; m1_wen = 1; m1_addr = DEV_MTIMECMP; m1_wdata = 64'hFFFF_0000;
    xfer(1'b1, 1'b0, 64'hDEAD_BEEF, 1'b0);
    chk("mtc_addr",  mmio_addr,  DEV_MTIMECMP);
    chk("mtc_wdata", mmio_wdata, 64'hFFFF_0000);
    m1_wen = 0;

    // Round-robin from reset with both ports permanently requesting
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    m0_valid = 1; m0_ren = 1; m0_addr = DEV_RTC;
    m1_valid = 1; m1_ren = 1; m1_addr = DEV_MTIMECMP;
    xfer(1'b0, 1'b1, 64'hA1, 1'b1);
    xfer(1'b1, 1'b1, 64'hB2, 1'b1);
    xfer(1'b0, 1'b1, 64'hC3, 1'b1);
    m0_valid = 0; m1_valid = 0; m1_ren = 0;

    // Device never answers: watchdog aborts after TIMEOUT wait cycles
    m0_valid = 1; m0_ren = 1; m0_addr = DEV_RTC;
    #1;
    chk("to_ready", m0_ready, 64'd1);
    @(negedge clk);
    chk("to_start", mmio_start, 64'd1);
    m0_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_wait_done", m0_done, 64'd0);
      chk("to_wait_busy", busy,    64'd1);
    end
    @(negedge clk);
    chk("to_done",  m0_done,  64'd1);
    chk("to_err",   m0_err,   64'd1);
    chk("to_rdata", m0_rdata, 64'd0);
    chk("to_ack",   mmio_ack, 64'd1);
    chk("to_other", m1_done,  64'd0);
    @(negedge clk);
    chk("to_idle",  busy,    64'd0);
    chk("to_pulse", m0_done, 64'd0);
    m0_ren = 0;
    m1_valid = 1; m1_ren = 1; m1_addr = DEV_RTC;
    xfer(1'b1, 1'b1, 64'h55, 1'b0);
    m1_ren = 0;

    // Illegal op (ren and wen both set): error pulse, no device access
    m0_valid = 1; m0_ren = 1; m0_wen = 1;
    #1;
    chk("ill_ready", m0_ready, 64'd1);
    @(negedge clk);
    chk("ill_done",  m0_done,    64'd1);
    chk("ill_err",   m0_err,     64'd1);
    chk("ill_rdata", m0_rdata,   64'd0);
    chk("ill_start", mmio_start, 64'd0);
    chk("ill_other", m1_done,    64'd0);
    m0_valid = 0; m0_ren = 0; m0_wen = 0;
    @(negedge clk);
    chk("ill_pulse",  m0_done,    64'd0);
    chk("ill_start2", mmio_start, 64'd0);
    chk("ill_idle",   busy,       64'd0);

    // Reset in WAIT with the device req still high afterwards
    m0_valid = 1; m0_ren = 1; m0_addr = DEV_RTC;
    #1;
    chk("rw_ready", m0_ready, 64'd1);
    @(negedge clk);
    chk("rw_start", mmio_start, 64'd1);
    m0_valid = 0;
    mmio_req = 1; mmio_rdata = 64'h77;
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rw_busy",  busy,       64'd0);
    chk("rw_done",  m0_done,    64'd0);
    chk("rw_start0", mmio_start, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rw_flush_ack",  mmio_ack, 64'd1);
    chk("rw_flush_busy", busy,     64'd1);
    chk("rw_flush_done", m0_done | m1_done, 64'd0);
    @(negedge clk);
    chk("rw_ack_hold", mmio_ack, 64'd1);
    chk("rw_no_done",  m0_done | m1_done, 64'd0);
    mmio_req = 0; mmio_rdata = 0;
    @(negedge clk);
    chk("rw_idle",  busy,     64'd0);
    chk("rw_ack0",  mmio_ack, 64'd0);
    chk("rw_done0", m0_done | m1_done, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
